// File: rtl/input_conditioner_pkg.sv
// Shared defaults for the input conditioner: channel count, debounce length,
// and the counter-width helper used by every channel.
package input_conditioner_pkg;

  localparam int DEFAULT_N         = 3;
  localparam int DEFAULT_DB_CYCLES = 4;

  // Counter must hold 0..db_cycles-1; sized one value larger to keep it safe at db_cycles=1.
  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioner channel: two-flop synchronizer, persistence counter,
// stable state and registered edge pulses.
module debounce_ch
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic o,
  output logic rise,
  output logic fall
);

  localparam int              CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          o_q, o_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of always_comb gets a default first so no path leaves a latch.
  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    o_d    = o_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == o_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Change has persisted long enough: accept it and pulse in the same edge.
      o_d    = s2_q;
      cnt_d  = '0;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      o_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      o_q    <= o_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// N independent debounced, synchronized inputs with registered rise/fall pulses;
// o feeds the downstream data-flow stage directly.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw,
  output logic [N-1:0] o,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar k = 0; k < N; k++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[k]),
      .o    (o[k]),
      .rise (rise[k]),
      .fall (fall[k])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: DB_CYCLES=4 and DB_CYCLES=1 instances share raw/rst_n
// and are compared each cycle against a sliding-window reference model.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] raw;
  logic [NCH-1:0] o4, rise4, fall4;
  logic [NCH-1:0] o1, rise1, fall1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  input_conditioner #(.N(NCH), .DB_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .raw(raw), .o(o4), .rise(rise4), .fall(fall4)
  );

  input_conditioner #(.N(NCH), .DB_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .raw(raw), .o(o1), .rise(rise1), .fall(fall1)
  );

  // Reference model: o flips at edge t when the synchronized level sampled at each
  // of the last DB edges (all after the previous flip) differs from o.
  int             db_of [2] = '{4, 1};
  logic [NCH-1:0] hist [$];
  logic [NCH-1:0] m_o    [2];
  logic [NCH-1:0] m_rise [2];
  logic [NCH-1:0] m_fall [2];
  int             m_last [2][NCH];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic raw_at(input int k, input int ch);
    if (k < 1) return 1'b0;
    return hist[k-1][ch];
  endfunction

  function automatic logic [NCH-1:0] dut_o(input int d);
    return (d == 0) ? o4 : o1;
  endfunction

  function automatic logic [NCH-1:0] dut_rise(input int d);
    return (d == 0) ? rise4 : rise1;
  endfunction

  function automatic logic [NCH-1:0] dut_fall(input int d);
    return (d == 0) ? fall4 : fall1;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 2; d++) begin
      m_o[d]    = '0;
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int ch = 0; ch < NCH; ch++) m_last[d][ch] = 0;
    end
  endtask

  task automatic model_edge();
    int t;
    hist.push_back(raw);
    t = hist.size();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        bit go;
        go = (t - db_of[d] >= m_last[d][ch]);
        for (int j = 0; j < db_of[d]; j++)
          if (raw_at(t - 2 - j, ch) == m_o[d][ch]) go = 1'b0;
        m_rise[d][ch] = go && !m_o[d][ch];
        m_fall[d][ch] = go &&  m_o[d][ch];
        if (go) begin
          m_o[d][ch]    = ~m_o[d][ch];
          m_last[d][ch] = t;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("o_db%0d", db_of[d]),    8'(dut_o(d)),    8'(m_o[d]));
      check($sformatf("rise_db%0d", db_of[d]), 8'(dut_rise(d)), 8'(m_rise[d]));
      check($sformatf("fall_db%0d", db_of[d]), 8'(dut_fall(d)), 8'(m_fall[d]));
      check($sformatf("overlap_db%0d", db_of[d]), 8'(dut_rise(d) & dut_fall(d)), 8'h00);
    end
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_o_db4",    8'(o4),    8'h00);
    check("rst_rise_db4", 8'(rise4), 8'h00);
    check("rst_fall_db4", 8'(fall4), 8'h00);
    check("rst_o_db1",    8'(o1),    8'h00);
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    rst_n = 1'b1;
    raw   = '0;
    #2;
    apply_reset(3);

    // Idle: everything stays at zero.
    repeat (20) tick();
    check("idle_o_db4", 8'(o4), 8'h00);

    // Single rise on channel 0: o changes after edge 6.
    raw = 3'b001;
    repeat (5) tick();
    check("lat_edge5_o", 8'(o4), 8'h00);
    tick();
    check("lat_edge6_o",    8'(o4),    8'h01);
    check("lat_edge6_rise", 8'(rise4), 8'h01);
    check("lat_edge6_fall", 8'(fall4), 8'h00);
    tick();
    check("lat_edge7_rise", 8'(rise4), 8'h00);

    // Three-cycle glitch on channel 1 is rejected; four cycles is accepted.
    pulses = 0;
    raw = 3'b011;
    repeat (3) begin tick(); pulses += int'(rise4[1]); end
    raw = 3'b001;
    repeat (8) begin tick(); pulses += int'(rise4[1]); end
    check("glitch_o1",     8'(o4[1]), 8'h00);
    check("glitch_pulses", 8'(pulses), 8'h00);
    pulses = 0;
    raw = 3'b011;
    repeat (4) begin tick(); pulses += int'(rise4[1]); end
    raw = 3'b001;
    repeat (3) begin tick(); pulses += int'(rise4[1]); end
    check("accept_pulses", 8'(pulses), 8'h01);
    repeat (12) tick();

    // All channels high, then all drop together.
    raw = 3'b111;
    repeat (10) tick();
    check("all_high_o", 8'(o4), 8'h07);
    raw = 3'b000;
    repeat (5) tick();
    check("drop_edge5_o", 8'(o4), 8'h07);
    tick();
    check("drop_edge6_o",    8'(o4),    8'h00);
    check("drop_edge6_fall", 8'(fall4), 8'h07);
    tick();
    check("drop_edge7_fall", 8'(fall4), 8'h00);

    // Reset mid-count on channel 2 discards the count; raw held high through reset.
    raw = 3'b100;
    repeat (5) tick();
    check("precount_o2", 8'(o4[2]), 8'h00);
    apply_reset(2);
    repeat (5) tick();
    check("post_rst_edge5_o", 8'(o4), 8'h00);
    tick();
    check("post_rst_edge6_o",    8'(o4),    8'h04);
    check("post_rst_edge6_rise", 8'(rise4), 8'h04);
    repeat (4) tick();

    // Toggle channel 0 every 3 cycles: DB=1 follows each change, DB=4 rejects them all.
    pulses = 0;
    begin
      int slow_pulses;
      slow_pulses = 0;
      for (int i = 0; i < 10; i++) begin
        raw[0] = ~raw[0];
        repeat (3) begin
          tick();
          pulses      += int'(rise1[0]) + int'(fall1[0]);
          slow_pulses += int'(rise4[0]) + int'(fall4[0]);
        end
      end
      repeat (3) begin
        tick();
        pulses      += int'(rise1[0]) + int'(fall1[0]);
        slow_pulses += int'(rise4[0]) + int'(fall4[0]);
      end
      check("db1_toggle_pulses", 8'(pulses), 8'd10);
      check("db4_toggle_pulses", 8'(slow_pulses), 8'd0);
    end

    // Randomized levels with occasional glitches and resets.
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(4) == 0) raw[ch] = ~raw[ch];
      if ($urandom_range(199) == 0) apply_reset(1 + $urandom_range(2));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: N, default 3, number of independent input channels; legal range 1..8.
REQ-002 Parameter: DB_CYCLES, default 4, consecutive clock cycles a synchronized change must persist before acceptance; legal range 1..255.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: raw  input  N  asynchronous switch/button levels, one bit per channel.
REQ-006 Port: o  output  N  debounced, synchronized levels; these feed the i0..i2 inputs of the downstream data-flow stage.
REQ-007 Port: rise  output  N  one-cycle pulse per channel when o[k] goes 0->1.
REQ-008 Port: fall  output  N  one-cycle pulse per channel when o[k] goes 1->0.
REQ-009 All outputs shall be driven directly from flops, with no combinational path from raw to any output.

Function
REQ-010 Each channel shall pass raw[k] through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 Each channel shall hold a stable state o[k] and a counter cnt[k] of width ceil(log2(DB_CYCLES+1)).
REQ-012 On each edge where s2[k] == o[k], cnt[k] shall load 0.
REQ-013 On each edge where s2[k] != o[k] and cnt[k] < DB_CYCLES-1, cnt[k] shall increment by 1.
REQ-014 On each edge where s2[k] != o[k] and cnt[k] == DB_CYCLES-1, o[k] shall load s2[k] and cnt[k] shall load 0 in the same edge.
REQ-015 rise[k] and fall[k] shall be registered and asserted in exactly the cycle in which o[k] holds its new value; both shall be 0 in every other cycle.
REQ-016 Latency: raw stable at a new level before edge 1 shall make o change after edge 2+DB_CYCLES (after edge 6 for DB_CYCLES=4), with a 1-cycle rise or fall pulse in that cycle.
REQ-017 Glitch rejection: any s2 excursion shorter than DB_CYCLES consecutive cycles shall reset cnt and leave o, rise and fall unchanged.
REQ-018 DB_CYCLES=1: o shall follow s2 with one cycle of delay, and every change shall still produce a pulse.
REQ-019 Channels shall be fully independent; simultaneous changes on several channels shall produce simultaneous pulses.
REQ-020 rise[k] and fall[k] shall never both be 1 in the same cycle.
REQ-021 cnt shall never exceed DB_CYCLES-1, and no wrap-around shall be possible.

Reset
REQ-022 rst_n low shall asynchronously clear s1, s2, cnt, o, rise and fall to 0 on all channels.
REQ-023 Reset asserted mid-count shall discard the count, and no pulse shall be emitted for the interrupted change.
REQ-024 If raw[k]=1 throughout reset, o[k] shall rise 2+DB_CYCLES edges after rst_n deasserts, with one rise pulse.

Structure
REQ-025 A shared package shall hold the default DB_CYCLES and N constants; no typedefs are required.
REQ-026 The per-channel logic (synchronizer, counter, state, pulses) shall be one sub-module, debounce_ch, instantiated N times through a generate loop.

Verification
REQ-027 Verification: reset, then raw=3'b000 for 20 cycles -> o=000, rise=fall=000 throughout.
REQ-028 Verification: raw[0] 0->1 before edge 1 (DB_CYCLES=4) -> o[0]=1 after edge 6, rise[0]=1 for exactly that one cycle, fall=000.
REQ-029 Verification: raw[1] high for 3 cycles, then low -> o[1] stays 0 and rise[1] never pulses; a subsequent 4-cycle high yields o[1]=1 with one rise pulse.
REQ-030 Verification: with o=111, raw drops to 000 on one edge -> o=000 after 6 edges and fall=111 in a single cycle.
REQ-031 Verification: raw[2]=1, rst_n pulsed low after 3 counted cycles -> o[2]=0 immediately, then rises 6 edges after release with one rise pulse.
REQ-032 Verification: run with DB_CYCLES=1, raw[0] toggled every 3 cycles -> o[0] follows with 3-edge latency, one pulse per toggle, rise and fall never overlapping.
